cross_entropy_grad_seq: RTL and testbench

CROSS_ENTROPY_GRAD_SEQ -- requirements
Module: cross_entropy_grad_seq

---
 rtl/cross_entropy_grad_seq.sv | 148 ++++++++++++++
 tb/tb_cross_entropy_grad_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cross_entropy_grad_seq.sv
// cross_entropy_grad_seq
//   Sequential cross-entropy gradient engine. For each element of a vector it
//   reads a prediction/label pair, clamps the prediction to [0, P_MAX], and
//   looks up 1/(1-p) using an external combinational table. The operand is p
//   for label 0 and P_MAX-p for label 1. It then writes the gradient back:
//   tbl_out for label 0, -tbl_out for label 1. Each element takes 3 cycles
//   (READ, LOOK, WRITE), plus any write back-pressure.
// Ports
//   clk, rst_n            clock, async active-low reset
//   start, len            vector request (honoured in IDLE only) and element count
//   busy, done            activity flag, one-cycle completion pulse
//   rd_en, rd_addr        memory read request; rd_pred/rd_label return 1 cycle later
//   tbl_in, tbl_out       lookup table operand / result
//   wr_en, wr_addr,       gradient write request, accepted when wr_ready is high
//   wr_data, wr_ready
//   clamp_cnt             clamped predictions in current/most recent vector
module cross_entropy_grad_seq #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int P_MAX  = 4095
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_pred,
  input  logic              rd_label,
  output logic [DATA_W-1:0] tbl_in,
  input  logic [DATA_W-1:0] tbl_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] clamp_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LOOK, S_WRITE, S_DONE} state_t;

  localparam logic signed [DATA_W-1:0] PMAX = DATA_W'(P_MAX);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] clamp_q, clamp_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic              lbl_q, lbl_d;

  // Clamp of the returned prediction; only consumed in LOOK.
  logic signed [DATA_W-1:0] pred_s, pred_cl;
  logic                     is_clamped;
  logic [ADDR_W-1:0]        idx_inc;

  assign pred_s  = $signed(rd_pred);
  assign idx_inc = idx_q + ADDR_W'(1);

  always_comb begin
    pred_cl    = pred_s;
    is_clamped = 1'b0;
    if (pred_s < 0) begin
      pred_cl    = '0;
      is_clamped = 1'b1;
    end else if (pred_s > PMAX) begin
      pred_cl    = PMAX;
      is_clamped = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    clamp_d = clamp_q;
    op_d    = op_q;
    lbl_d   = lbl_q;
    busy    = 1'b1;
    done    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    tbl_in  = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          idx_d   = '0;
          clamp_d = '0;
          len_d   = len;
          state_d = (len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        rd_en   = 1'b1;
        rd_addr = idx_q;
        state_d = S_LOOK;
      end
      S_LOOK: begin
        op_d  = rd_label ? DATA_W'(PMAX - pred_cl) : DATA_W'(pred_cl);
        lbl_d = rd_label;
        if (is_clamped && clamp_q != '1) clamp_d = clamp_q + ADDR_W'(1);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Everything here is driven from registers or the combinational
        // table, so outputs stay constant while the sink stalls.
        tbl_in  = op_q;
        wr_en   = 1'b1;
        wr_addr = idx_q;
        wr_data = lbl_q ? DATA_W'(-tbl_out) : tbl_out;
        if (wr_ready) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      clamp_q <= '0;
      op_q    <= '0;
      lbl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      clamp_q <= clamp_d;
      op_q    <= op_d;
      lbl_q   <= lbl_d;
    end
  end

  assign clamp_cnt = clamp_q;

endmodule

// File: tb/tb_cross_entropy_grad_seq.sv
// Testbench for cross_entropy_grad_seq: directed vectors, write scoreboard.
module tb_cross_entropy_grad_seq;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          start = 0;
  logic [AW-1:0] len = '0;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr, clamp_cnt;
  logic [DW-1:0] rd_pred = '0;
  logic          rd_label = 0;
  logic [DW-1:0] tbl_in, tbl_out, wr_data;
  logic          wr_ready = 1;

  cross_entropy_grad_seq #(.DATA_W(DW), .ADDR_W(AW), .P_MAX(4095)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_pred(rd_pred), .rd_label(rd_label),
    .tbl_in(tbl_in), .tbl_out(tbl_out), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .clamp_cnt(clamp_cnt));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory and table models.
  logic [DW-1:0] pred_mem [256];
  logic          lbl_mem  [256];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_pred  <= pred_mem[rd_addr];
      rd_label <= lbl_mem[rd_addr];
    end
  end

  function automatic logic [DW-1:0] tbl_f(input logic [DW-1:0] x);
    if (x == 16'd4094) return 16'd2048;
    if (x == 16'd2047) return 16'd1;
    return x + 16'd1;
  endfunction

  always_comb tbl_out = tbl_f(tbl_in);

  // Scoreboard of expected writes.
  typedef struct { int addr; int data; int tin; } wr_t;
  wr_t exp_q[$];

  task automatic push_wr(input int a, input int d, input int t);
    wr_t e;
    e.addr = a; e.data = d; e.tin = t;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if ((int'(rd_en) + int'(wr_en) + int'(done)) > 1)
      chk("exclusive_rd_wr_done", 1, 0);
    if (rst_n && wr_en && wr_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", int'(wr_addr), -1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", int'(wr_addr), e.addr);
        chk("wr_data", int'($signed(wr_data)), e.data);
        chk("tbl_in", int'(tbl_in), e.tin);
      end
    end
  end

  // Back-pressure driver: hold wr_ready low for stall_left cycles of WRITE
  // and verify the write request stays frozen with no read issued.
  int            stall_left = 0;
  bit            stalling = 0;
  logic [AW-1:0] snap_a;
  logic [DW-1:0] snap_d;

  always begin
    @(posedge clk);
    #2;
    if (wr_en && stall_left > 0) begin
      if (stalling) begin
        chk("stall_hold_addr", int'(wr_addr), int'(snap_a));
        chk("stall_hold_data", int'(wr_data), int'(snap_d));
        chk("stall_no_read", int'(rd_en), 0);
      end
      snap_a = wr_addr; snap_d = wr_data;
      stalling = 1; stall_left--; wr_ready = 0;
    end else begin
      stalling = 0; wr_ready = 1;
    end
  end

  // Issue a vector and measure cycles until done is seen.
  task automatic run_vec(input int n, input int exp_cyc, input int exp_clamp,
                         input bit poke, input string name);
    int cyc;
    @(negedge clk);
    start = 1; len = AW'(n);
    @(negedge clk);
    start = 0;
    cyc = 1;
    while (!done && cyc < 200) begin
      start = (poke && cyc == 2);
      if (poke && cyc == 2) len = 8'd9;
      @(negedge clk);
      start = 0;
      cyc++;
    end
    chk({name, "_latency"}, cyc, exp_cyc);
    chk({name, "_busy_in_done"}, int'(busy), 1);
    chk({name, "_clamp_cnt"}, int'(clamp_cnt), exp_clamp);
    @(negedge clk);
    chk({name, "_idle_busy"}, int'(busy), 0);
    chk({name, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin pred_mem[i] = '0; lbl_mem[i] = 0; end
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_tbl_in", int'(tbl_in), 0);
    chk("rst_clamp", int'(clamp_cnt), 0);
    rst_n = 1;

    // Single element, label 0, table maps 4094 to 2048.
    pred_mem[0] = 16'd4094; lbl_mem[0] = 0;
    push_wr(0, 2048, 4094);
    run_vec(1, 4, 0, 0, "v1");

    // Label 1: operand 4095-2048=2047, table gives 1, gradient -1.
    pred_mem[0] = 16'd2048; lbl_mem[0] = 1;
    push_wr(0, -1, 2047);
    run_vec(1, 4, 0, 0, "v2");

    // Clamping both ways; a stray start mid-vector must be ignored.
    pred_mem[0] = 16'hFFFB; pred_mem[1] = 16'd5000; pred_mem[2] = 16'd100;
    lbl_mem[0] = 0; lbl_mem[1] = 0; lbl_mem[2] = 0;
    push_wr(0, 1, 0); push_wr(1, 4096, 4095); push_wr(2, 101, 100);
    run_vec(3, 10, 2, 1, "v3");

    // Back-pressure on the first write: 5 extra cycles.
    pred_mem[0] = 16'd200; lbl_mem[0] = 0;
    pred_mem[1] = 16'd300; lbl_mem[1] = 1;
    push_wr(0, 201, 200); push_wr(1, -3796, 3795);
    stall_left = 5;
    run_vec(2, 12, 0, 0, "v4");
    chk("v4_stall_consumed", stall_left, 0);

    // Empty vector: done right away, no traffic (monitor flags any write).
    run_vec(0, 1, 0, 0, "v5");

    // Reset in LOOK of element 1 of a 4-element vector.
    for (int i = 0; i < 4; i++) begin pred_mem[i] = DW'(10 * (i + 1)); lbl_mem[i] = 0; end
    pred_mem[0] = 16'hFFFF;
    push_wr(0, 1, 0);
    @(negedge clk);
    start = 1; len = 8'd4;
    @(negedge clk);
    start = 0;
    begin
      int rds = 0;
      int guard = 0;
      while (rds < 2 && guard < 50) begin
        if (rd_en) rds++;
        if (rds < 2) @(negedge clk);
        guard++;
      end
      chk("v6_reached_second_read", rds, 2);
    end
    @(negedge clk);
    chk("v6_clamp_before_rst", int'(clamp_cnt), 1);
    rst_n = 0;
    #1;
    chk("v6_rst_busy", int'(busy), 0);
    chk("v6_rst_rd_en", int'(rd_en), 0);
    chk("v6_rst_wr_en", int'(wr_en), 0);
    chk("v6_rst_done", int'(done), 0);
    chk("v6_rst_tbl_in", int'(tbl_in), 0);
    chk("v6_rst_wr_data", int'(wr_data), 0);
    chk("v6_rst_clamp", int'(clamp_cnt), 0);
    chk("v6_rst_addr", int'(rd_addr) + int'(wr_addr), 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("v6_queue_after_rst", exp_q.size(), 0);

    // Fresh vector after reset: pred 7 label 1 -> operand 4088, data -4089.
    pred_mem[0] = 16'd7; lbl_mem[0] = 1;
    push_wr(0, -4089, 4088);
    run_vec(1, 4, 0, 0, "v7");

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
